operand_encoder: RTL
====================

# operand_encoder

Sequential x86-64 operand encoder, the inverse of the operand decode stage. It accepts one operand descriptor per request: addressing form, r/m operand, reg operand, displacement and immediate. It streams the encoded ModRM, SIB, displacement and immediate bytes out one per cycle over a valid/ready handshake, then reports the REX R/X/B bits and the total length. It sits in the instruction re-encode/trace path, downstream of the instruction record builder and upstream of the byte sink that prepends prefixes and opcode.

## Interface
Parameters:
- RIP_ID, 8'h10, register id that selects rip-relative addressing
- NONE_ID, 8'h00, register id meaning "no register" (no base / no index)

General-purpose registers are always {4'b1000, code[3:0]}.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  encoder idle, can accept
- req_mode  in  3  0 Ev, 1 Ev_Gv, 2 Gv_Ev, 3 Ev_Ib, 4 Ev_Iz, 5 rax_Iz, 6 Jz, 7 Jb
- req_rm_mem  in  1  r/m operand: 0 register, 1 memory
- req_base  in  8  r/m base register id
- req_index  in  8  SIB index register id
- req_scale  in  2  SIB scale code
- req_disp  in  32  signed displacement
- req_reg  in  8  Gv register id; for Ev/Ev_Ib/Ev_Iz, bits [2:0] give the /digit and bit 3 must be 0
- req_imm  in  32  immediate or branch offset
- out_valid  out  1  out_byte valid
- out_ready  in  1  sink accepts byte
- out_byte  out  8  encoded byte
- out_last  out  1  final byte of the request
- done  out  1  one-cycle completion pulse
- error  out  1  qualifies done: request rejected
- len  out  4  bytes emitted (0..10), valid with done
- rex_rxb  out  3  {R,X,B}, valid with done

## Operation
FSM states:
- IDLE: req_ready=1.
- EMIT: streams bytes from a 10-byte buffer plus a count.
- FIN: pulses done, returns to IDLE.

On accept, the block computes the encoding and loads the buffer in this order: ModRM, SIB, disp (LE), imm (LE).

ModRM is present for modes 0–4 only. Modes 5–7 carry no ModRM.

ModRM reg field:
- Gv modes: req_reg[2:0], R=req_reg[3].
- Otherwise: the /digit, R=0.

Register r/m: mod=11, rm=base[2:0], B=base[3]. No SIB, no disp.

rip-relative memory (base==RIP_ID): mod=00, rm=101, disp32. An index other than NONE_ID is an error.

SIB is required when index≠NONE_ID, base[2:0]==100, or base==NONE_ID. In that case rm=100 and:
- SIB scale = req_scale.
- SIB index = index[2:0], X=index[3]; index NONE_ID encodes 100 with X=0.
- Index rsp (8'h84) is an error.
- base NONE_ID: mod=00, SIB base=101, disp32, B=0.
- Otherwise SIB base = base[2:0], B=base[3].

Displacement and mod for a real base:
- disp==0 and base[2:0]≠101: mod=00, no disp.
- disp in [-128,127]: mod=01, disp8.
- Otherwise: mod=10, disp32.
- A base code of 101 with disp 0 therefore emits a disp8 of 0x00.

Immediate width:
- Ib, Jb: 1 byte.
- Iz, rax_Iz, Jz: 4 bytes.
- Jb with imm outside [-128,127] is an error.

Other errors:
- Gv register, register-form base, or memory base (other than RIP_ID/NONE_ID) that is not a GPR.
- Register r/m with req_rm_mem=0 and base NONE_ID.

Error handling: nothing is emitted, and the FSM goes to FIN with error=1, len=0, rex_rxb=0.

## Timing
- Reset values: req_ready=0 while reset is low and 1 from the first cycle after release; out_valid, out_byte, out_last, done, error, len and rex_rxb are all 0.
- Accept: req_valid&&req_ready in IDLE. The descriptor is captured and req_ready drops the next cycle.
- The first byte presents one cycle after accept (out_valid=1).
- Each out_valid&&out_ready handshake advances one byte.
- out_byte and out_last are held stable while out_ready=0.
- out_last=1 only with the final byte.
- The cycle after the final handshake is FIN: done=1 for exactly one cycle, with len and rex_rxb.
- IDLE (req_ready=1) follows in the next cycle, so back-to-back throughput is len+2 cycles per request when no stall occurs.
- Error path: accept → FIN (done=1, error=1) → IDLE. out_valid never rises.
- Reset low mid-stream: all outputs are forced to reset values the next edge. No done is issued for the aborted request.
- req_* inputs outside the accept cycle are ignored.

## Test plan
- Ev_Gv reg-reg: base=8'h83, reg=8'h80 → single byte 0xC3 with out_last; done with len=1, rex_rxb=3'b000.
- Gv_Ev [rsp+8]: reg=8'h81, base=8'h84, index=NONE, disp=8 → bytes 4C 24 08; len=3.
- Ev_Iz [rip+0x12345678], /0, imm=0xDEADBEEF → bytes 05 78 56 34 12 EF BE AD DE; out_last on the 9th byte; len=9.
- Gv_Ev [r13+r9*4]: reg=8'h88, base=8'h8D, index=8'h89, scale=2, disp=0 → bytes 44 8D 00; rex_rxb=3'b111.
- Backpressure and reset: hold out_ready=0 for 3 cycles mid-stream → byte and out_last held stable. Then drop reset mid-stream → out_valid=0 next cycle, no done, req_ready=1 after reset release.
- Errors:
  - index=8'h84 → done&error, len=0, no out_valid.
  - Jb imm=0x80 → error.
  - A subsequent valid Jb imm=0xFFFFFFFE → byte FE, len=1.

Source files
------------

// File: rtl/operand_encoder.sv
// operand_encoder: turns one x86-64 operand descriptor into its ModRM, SIB,
// displacement and immediate bytes, streams them one per cycle over a
// valid/ready handshake, then pulses done with the byte count and REX R/X/B.
module operand_encoder #(
   parameter logic [7:0] RIP_ID  = 8'h10,
   parameter logic [7:0] NONE_ID = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_mode,
   input  logic        req_rm_mem,
   input  logic [7:0]  req_base,
   input  logic [7:0]  req_index,
   input  logic [1:0]  req_scale,
   input  logic [31:0] req_disp,
   input  logic [7:0]  req_reg,
   input  logic [31:0] req_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_byte,
   output logic        out_last,
   output logic        done,
   output logic        error,
   output logic [3:0]  len,
   output logic [2:0]  rex_rxb
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EMIT = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   localparam logic [2:0] M_EV     = 3'd0;
   localparam logic [2:0] M_EV_GV  = 3'd1;
   localparam logic [2:0] M_GV_EV  = 3'd2;
   localparam logic [2:0] M_EV_IB  = 3'd3;
   localparam logic [2:0] M_EV_IZ  = 3'd4;
   localparam logic [2:0] M_RAX_IZ = 3'd5;
   localparam logic [2:0] M_JZ     = 3'd6;
   localparam logic [2:0] M_JB     = 3'd7;

   localparam logic [7:0] RSP_ID = 8'h84;

   logic [1:0]  state_q, state_d;
   logic        ready_q;
   logic [79:0] buf_q;
   logic [3:0]  cnt_q;
   logic [3:0]  len_q;
   logic [2:0]  rex_q;
   logic        err_q;

   // Encoding derived straight from the request inputs; only used on accept.
   logic        enc_err;
   logic        has_modrm;
   logic        has_sib;
   logic        is_gv;
   logic [1:0]  mod_f;
   logic [2:0]  reg_f;
   logic [2:0]  rm_f;
   logic [2:0]  sib_idx;
   logic [2:0]  sib_base;
   logic [3:0]  disp_len;
   logic [3:0]  imm_len;
   logic        rex_r, rex_x, rex_b;
   logic [7:0]  modrm_byte;
   logic [7:0]  sib_byte;
   logic [3:0]  modrm_len;
   logic [3:0]  off_disp;
   logic [3:0]  off_imm;
   logic [3:0]  enc_len;
   logic [79:0] load_vec;
   logic        accept;
   logic        disp_fits8;
   logic        imm_fits8;

   function automatic logic is_gpr(input logic [7:0] id);
      return id[7:4] == 4'b1000;
   endfunction

   assign accept     = req_valid && ready_q && (state_q == S_IDLE);
   assign disp_fits8 = (req_disp[31:7] == 25'h0) || (req_disp[31:7] == 25'h1FF_FFFF);
   assign imm_fits8  = (req_imm[31:7] == 25'h0) || (req_imm[31:7] == 25'h1FF_FFFF);

   // Decode the descriptor into ModRM/SIB fields, field lengths, REX bits and errors.
   always_comb begin
      enc_err   = 1'b0;
      has_modrm = (req_mode <= M_EV_IZ);
      is_gv     = (req_mode == M_EV_GV) || (req_mode == M_GV_EV);
      has_sib   = 1'b0;
      mod_f     = 2'b00;
      reg_f     = 3'b000;
      rm_f      = 3'b000;
      sib_idx   = 3'b100;
      sib_base  = 3'b000;
      disp_len  = 4'd0;
      imm_len   = 4'd0;
      rex_r     = 1'b0;
      rex_x     = 1'b0;
      rex_b     = 1'b0;

      case (req_mode)
         M_EV_IB, M_JB:           imm_len = 4'd1;
         M_EV_IZ, M_RAX_IZ, M_JZ: imm_len = 4'd4;
         default:                 imm_len = 4'd0;
      endcase

      if (req_mode == M_JB && !imm_fits8) begin
         enc_err = 1'b1;
      end

      if (has_modrm) begin
         // Gv modes carry a register in the reg field; the rest carry a /digit.
         reg_f = req_reg[2:0];
         if (is_gv) begin
            rex_r = req_reg[3];
            if (!is_gpr(req_reg)) begin
               enc_err = 1'b1;
            end
         end

         if (!req_rm_mem) begin
            mod_f = 2'b11;
            rm_f  = req_base[2:0];
            rex_b = req_base[3];
            if (req_base == NONE_ID || !is_gpr(req_base)) begin
               enc_err = 1'b1;
            end
         end else if (req_base == RIP_ID) begin
            mod_f    = 2'b00;
            rm_f     = 3'b101;
            disp_len = 4'd4;
            if (req_index != NONE_ID) begin
               enc_err = 1'b1;
            end
         end else begin
            if (req_base != NONE_ID && !is_gpr(req_base)) begin
               enc_err = 1'b1;
            end
            has_sib = (req_index != NONE_ID) || (req_base[2:0] == 3'b100) ||
                      (req_base == NONE_ID);
            rm_f = has_sib ? 3'b100 : req_base[2:0];
            if (has_sib) begin
               if (req_index == RSP_ID) begin
                  enc_err = 1'b1;
               end
               if (req_index != NONE_ID) begin
                  sib_idx = req_index[2:0];
                  rex_x   = req_index[3];
               end
            end
            if (req_base == NONE_ID) begin
               // No base: SIB base 101 with mod 00 means disp32 only.
               mod_f    = 2'b00;
               sib_base = 3'b101;
               disp_len = 4'd4;
            end else begin
               sib_base = req_base[2:0];
               rex_b    = req_base[3];
               // Base code 101 with mod 00 would mean rip/no-base, so a zero
               // displacement there still needs an explicit disp8.
               if (req_disp == 32'h0 && req_base[2:0] != 3'b101) begin
                  mod_f    = 2'b00;
                  disp_len = 4'd0;
               end else if (disp_fits8) begin
                  mod_f    = 2'b01;
                  disp_len = 4'd1;
               end else begin
                  mod_f    = 2'b10;
                  disp_len = 4'd4;
               end
            end
         end
      end
   end

   assign modrm_byte = {mod_f, reg_f, rm_f};
   assign sib_byte   = {req_scale, sib_idx, sib_base};
   assign modrm_len  = has_modrm ? 4'd1 : 4'd0;
   assign off_disp   = modrm_len + (has_sib ? 4'd1 : 4'd0);
   assign off_imm    = off_disp + disp_len;
   assign enc_len    = off_imm + imm_len;

   // Each buffer byte picks from whichever field covers its position.
   generate
      for (genvar gi = 0; gi < 10; gi++) begin : g_buf
         localparam logic [3:0] POS = 4'(gi);
         logic [1:0] dsel;
         logic [1:0] isel;
         assign dsel = 2'(POS - off_disp);
         assign isel = 2'(POS - off_imm);
         assign load_vec[8*gi +: 8] =
            (POS < modrm_len) ? modrm_byte :
            (POS < off_disp)  ? sib_byte :
            (POS < off_imm)   ? req_disp[{dsel, 3'b000} +: 8] :
            (POS < enc_len)   ? req_imm[{isel, 3'b000} +: 8] :
                                8'h00;
      end
   endgenerate

   // Next-state logic: IDLE -> EMIT (or FIN on error) -> FIN -> IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = enc_err ? S_FIN : S_EMIT;
         S_EMIT: if (out_ready && cnt_q == 4'd1) state_d = S_FIN;
         S_FIN:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, byte buffer and completion information registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ready_q <= 1'b0;
         buf_q   <= '0;
         cnt_q   <= 4'd0;
         len_q   <= 4'd0;
         rex_q   <= 3'b000;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == S_IDLE);
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  err_q <= enc_err;
                  len_q <= enc_err ? 4'd0 : enc_len;
                  cnt_q <= enc_err ? 4'd0 : enc_len;
                  rex_q <= enc_err ? 3'b000 : {rex_r, rex_x, rex_b};
                  buf_q <= enc_err ? 80'h0 : load_vec;
               end
            end
            S_EMIT: begin
               if (out_ready) begin
                  buf_q <= {8'h00, buf_q[79:8]};
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready = ready_q;
   assign out_valid = (state_q == S_EMIT);
   assign out_byte  = out_valid ? buf_q[7:0] : 8'h00;
   assign out_last  = out_valid && (cnt_q == 4'd1);
   assign done      = (state_q == S_FIN);
   assign error     = done && err_q;
   assign len       = done ? len_q : 4'd0;
   assign rex_rxb   = done ? rex_q : 3'b000;

endmodule
